id_exe_stage_reg: RTL and testbench
===================================

// Module: id_exe_stage_reg
// PURPOSE
//  ID->EXE pipeline register of the ARM core. Captures decoded control and operands from ID,
//  including the Rm value, shift_operand, imm and mem flags consumed by the EXE-stage Val2 path.
//  Implements hold (freeze), kill (flush) and hazard bubble insertion, plus small perf counters.
// PARAMETERS
//  DATA_W      32  width of PC and register operands
//  REG_W       4   register-index width
//  CMD_W       4   ALU exe_cmd width
//  CNT_W       16  width of the saturating bubble/flush counters
// PORTS
//  clk               in   1        rising-edge clock
//  rst               in   1        asynchronous, active-low reset
//  freeze            in   1        global hold (memory wait); highest non-reset priority
//  flush             in   1        branch taken in EXE; kill the instruction entering EXE
//  hazard            in   1        RAW hazard in ID; load a bubble instead of the ID instruction
//  pc_in             in   DATA_W   PC+4 of the ID instruction
//  wb_en_in          in   1        writeback enable
//  mem_r_en_in       in   1        load
//  mem_w_en_in       in   1        store
//  b_in              in   1        branch
//  s_in              in   1        update status flags
//  exe_cmd_in        in   CMD_W    ALU command
//  val_rn_in         in   DATA_W   Rn value
//  val_rm_in         in   DATA_W   Rm value
//  imm_in            in   1        I bit
//  shift_operand_in  in   12       shift_operand[11:0]
//  signed_imm24_in   in   24       branch offset
//  dest_in           in   REG_W    destination register
//  src1_in, src2_in  in   REG_W    source indices for forwarding
//  sr_in             in   4        NZCV at ID time (carry-in for ALU)
//  <x>_out           out  same     registered copy of every <x>_in above
//  is_mem_out        out  1        registered (mem_r_en_in | mem_w_en_in); drives is_mem_instruction
//  valid_out         out  1        1 = EXE holds a real instruction, 0 = bubble/killed
//  bubble_cnt        out  CNT_W    hazard bubbles inserted, saturating
//  flush_cnt         out  CNT_W    flushes applied, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): every output 0, counters 0, valid_out 0; release is synchronous to clk.
//  - Per rising edge, first-match priority:
//    1 freeze=1: all state holds, incl. counters; flush/hazard ignored that cycle.
//      The branch in EXE is held as well, so flush is re-presented next cycle.
//    2 flush=1: control fields (wb_en, mem_r_en, mem_w_en, b, s, is_mem, valid) <= 0,
//      exe_cmd <= 0; data fields may load freely. flush_cnt += 1.
//    3 hazard=1: same clearing as flush; bubble_cnt += 1.
//    4 otherwise: all fields <= inputs; valid_out <= 1.
//  - Latency 1 cycle ID->EXE. No combinational input->output path.
//  - flush+hazard together: treat as flush only; only flush_cnt increments.
//  - Counters saturate at all-ones; never wrap.
//  - Bubble invariant: valid_out=0 implies all control outputs 0, so a bubble cannot
//    write a register, access memory, branch or update SR.
//  - Reset mid-freeze: reset wins immediately; after release, the register loads normally.
// STRUCTURE
//  - Shared package/header arm_defs: CMD_W, REG_W, exe_cmd encodings, the NZCV bit order.
//  - One sub-module, sat_counter (CNT_W, inc, hold, rst), instanced twice.
//  - Control and data held in separate always blocks; the clearing logic touches control only.
// TESTING
//  - Reset: load all fields to nonzero, then pulse rst=0 mid-cycle -> all outputs 0 with no clk edge.
//  - Load: pc_in=32'h10, exe_cmd=4'b0010, shift_operand=12'h1A3, imm=1 -> next edge outputs equal, valid_out=1.
//  - Freeze: freeze=1 for 3 cycles while inputs change; also assert flush -> outputs and counters unchanged.
//  - Flush vs hazard: flush=1, hazard=1, wb_en_in=1 -> wb_en_out=0, valid_out=0, flush_cnt=1, bubble_cnt=0.
//  - Bubble: hazard=1 with mem_w_en_in=1 -> mem_w_en_out=0, is_mem_out=0, bubble_cnt increments.
//  - Saturation: CNT_W=2, 5 hazards in a row -> bubble_cnt=2'b11 and stays.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared ARM core definitions: default widths, ALU command encodings, NZCV bit order
// and the packed control bundle carried down the pipeline.
package arm_defs;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 4;
   localparam int DEF_CMD_W  = 4;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [3:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001
   } exe_cmd_e;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   typedef struct packed {
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic b;
      logic s;
      logic is_mem;
      logic valid;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with hold; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && !hold && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze, flush/hazard bubble insertion and
// saturating bubble/flush counters.
module id_exe_stage_reg
   import arm_defs::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W,
   parameter int CMD_W  = DEF_CMD_W,
   parameter int CNT_W  = DEF_CNT_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              hazard,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              b_in,
   input  logic              s_in,
   input  logic [CMD_W-1:0]  exe_cmd_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic              imm_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       signed_imm24_in,
   input  logic [REG_W-1:0]  dest_in,
   input  logic [REG_W-1:0]  src1_in,
   input  logic [REG_W-1:0]  src2_in,
   input  logic [3:0]        sr_in,
   output logic [DATA_W-1:0] pc_out,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic              mem_w_en_out,
   output logic              b_out,
   output logic              s_out,
   output logic [CMD_W-1:0]  exe_cmd_out,
   output logic [DATA_W-1:0] val_rn_out,
   output logic [DATA_W-1:0] val_rm_out,
   output logic              imm_out,
   output logic [11:0]       shift_operand_out,
   output logic [23:0]       signed_imm24_out,
   output logic [REG_W-1:0]  dest_out,
   output logic [REG_W-1:0]  src1_out,
   output logic [REG_W-1:0]  src2_out,
   output logic [3:0]        sr_out,
   output logic              is_mem_out,
   output logic              valid_out,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   always_comb begin
      ctrl_d          = CTRL_BUBBLE;
      ctrl_d.wb_en    = wb_en_in;
      ctrl_d.mem_r_en = mem_r_en_in;
      ctrl_d.mem_w_en = mem_w_en_in;
      ctrl_d.b        = b_in;
      ctrl_d.s        = s_in;
      ctrl_d.is_mem   = mem_r_en_in | mem_w_en_in;
      ctrl_d.valid    = 1'b1;
   end

   // Only the control side is cleared on a bubble, so a killed slot can never commit anything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q      <= CTRL_BUBBLE;
         exe_cmd_out <= '0;
      end else if (!freeze) begin
         if (flush || hazard) begin
            ctrl_q      <= CTRL_BUBBLE;
            exe_cmd_out <= '0;
         end else begin
            ctrl_q      <= ctrl_d;
            exe_cmd_out <= exe_cmd_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         signed_imm24_out  <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
         sr_out            <= '0;
      end else if (!freeze) begin
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         signed_imm24_out  <= signed_imm24_in;
         dest_out          <= dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
         sr_out            <= sr_in;
      end
   end

   assign wb_en_out    = ctrl_q.wb_en;
   assign mem_r_en_out = ctrl_q.mem_r_en;
   assign mem_w_en_out = ctrl_q.mem_w_en;
   assign b_out        = ctrl_q.b;
   assign s_out        = ctrl_q.s;
   assign is_mem_out   = ctrl_q.is_mem;
   assign valid_out    = ctrl_q.valid;

   // A simultaneous flush and hazard is accounted as a flush only.
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .hold  (freeze),
      .count (flush_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hazard & ~flush),
      .hold  (freeze),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: a behavioural model queues expected EXE state
// per clock, a monitor compares it; a second instance with 2-bit counters covers saturation.
module tb_id_exe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, hazard;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
   logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm24_in;

   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, is_mem_out, valid_out;
   logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm24_out;
   logic [15:0] bubble_cnt, flush_cnt;

   logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
   logic        s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out, s_b_out, s_s_out, s_imm_out, s_is_mem_out, s_valid_out;
   logic [3:0]  s_exe_cmd_out, s_dest_out, s_src1_out, s_src2_out, s_sr_out;
   logic [11:0] s_shift_operand_out;
   logic [23:0] s_signed_imm24_out;
   logic [1:0]  s_bubble_cnt, s_flush_cnt;

   typedef struct {
      logic [31:0] pc, rn, rm;
      logic        wb_en, mem_r, mem_w, b, s, imm, is_mem, valid;
      logic [3:0]  cmd, dest, src1, src2, sr;
      logic [11:0] sh;
      logic [23:0] off;
      int          bcnt, fcnt;
   } exp_t;

   exp_t m;
   exp_t mon_e;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_exe_stage_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
      .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .imm_in(imm_in), .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
      .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .val_rn_out(val_rn_out),
      .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
      .signed_imm24_out(signed_imm24_out), .dest_out(dest_out), .src1_out(src1_out),
      .src2_out(src2_out), .sr_out(sr_out), .is_mem_out(is_mem_out), .valid_out(valid_out),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   id_exe_stage_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
      .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .imm_in(imm_in), .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
      .pc_out(s_pc_out), .wb_en_out(s_wb_en_out), .mem_r_en_out(s_mem_r_en_out),
      .mem_w_en_out(s_mem_w_en_out), .b_out(s_b_out), .s_out(s_s_out), .exe_cmd_out(s_exe_cmd_out),
      .val_rn_out(s_val_rn_out), .val_rm_out(s_val_rm_out), .imm_out(s_imm_out),
      .shift_operand_out(s_shift_operand_out), .signed_imm24_out(s_signed_imm24_out),
      .dest_out(s_dest_out), .src1_out(s_src1_out), .src2_out(s_src2_out), .sr_out(s_sr_out),
      .is_mem_out(s_is_mem_out), .valid_out(s_valid_out),
      .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
   );

   function automatic int satv(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Data fields are only meaningful for a real instruction (or right after reset).
   task automatic check_output(input exp_t e, input bit all);
      check("wb_en", 64'(wb_en_out), 64'(e.wb_en));
      check("mem_r_en", 64'(mem_r_en_out), 64'(e.mem_r));
      check("mem_w_en", 64'(mem_w_en_out), 64'(e.mem_w));
      check("b", 64'(b_out), 64'(e.b));
      check("s", 64'(s_out), 64'(e.s));
      check("exe_cmd", 64'(exe_cmd_out), 64'(e.cmd));
      check("is_mem", 64'(is_mem_out), 64'(e.is_mem));
      check("valid", 64'(valid_out), 64'(e.valid));
      check("bubble_cnt", 64'(bubble_cnt), 64'(satv(e.bcnt, 65535)));
      check("flush_cnt", 64'(flush_cnt), 64'(satv(e.fcnt, 65535)));
      check("sat_valid", 64'(s_valid_out), 64'(e.valid));
      check("sat_bubble_cnt", 64'(s_bubble_cnt), 64'(satv(e.bcnt, 3)));
      check("sat_flush_cnt", 64'(s_flush_cnt), 64'(satv(e.fcnt, 3)));
      if (all || e.valid) begin
         check("pc", 64'(pc_out), 64'(e.pc));
         check("val_rn", 64'(val_rn_out), 64'(e.rn));
         check("val_rm", 64'(val_rm_out), 64'(e.rm));
         check("imm", 64'(imm_out), 64'(e.imm));
         check("shift_operand", 64'(shift_operand_out), 64'(e.sh));
         check("signed_imm24", 64'(signed_imm24_out), 64'(e.off));
         check("dest", 64'(dest_out), 64'(e.dest));
         check("src1", 64'(src1_out), 64'(e.src1));
         check("src2", 64'(src2_out), 64'(e.src2));
         check("sr", 64'(sr_out), 64'(e.sr));
      end
   endtask

   task automatic reset_model();
      m = '{default: '0};
   endtask

   task automatic randomize_inputs();
      pc_in            = $urandom;
      wb_en_in         = 1'($urandom_range(0, 1));
      mem_r_en_in      = 1'($urandom_range(0, 1));
      mem_w_en_in      = 1'($urandom_range(0, 1));
      b_in             = 1'($urandom_range(0, 1));
      s_in             = 1'($urandom_range(0, 1));
      exe_cmd_in       = 4'($urandom_range(0, 15));
      val_rn_in        = $urandom;
      val_rm_in        = $urandom;
      imm_in           = 1'($urandom_range(0, 1));
      shift_operand_in = 12'($urandom);
      signed_imm24_in  = 24'($urandom);
      dest_in          = 4'($urandom);
      src1_in          = 4'($urandom);
      src2_in          = 4'($urandom);
      sr_in            = 4'($urandom);
   endtask

   // One ID->EXE transfer: the model applies the priority rules to what will be captured.
   task automatic apply_stimulus(input logic fr, input logic fl, input logic hz, input bit rnd);
      @(negedge clk);
      if (rnd) randomize_inputs();
      freeze = fr;
      flush  = fl;
      hazard = hz;
      if (!fr) begin
         m.pc = pc_in;   m.rn = val_rn_in;   m.rm = val_rm_in;   m.imm = imm_in;
         m.sh = shift_operand_in;   m.off = signed_imm24_in;
         m.dest = dest_in;   m.src1 = src1_in;   m.src2 = src2_in;   m.sr = sr_in;
         if (fl || hz) begin
            m.wb_en = 0; m.mem_r = 0; m.mem_w = 0; m.b = 0; m.s = 0;
            m.is_mem = 0; m.valid = 0; m.cmd = '0;
            if (fl) m.fcnt++;
            else    m.bcnt++;
         end else begin
            m.wb_en = wb_en_in; m.mem_r = mem_r_en_in; m.mem_w = mem_w_en_in;
            m.b = b_in; m.s = s_in; m.cmd = exe_cmd_in;
            m.is_mem = mem_r_en_in | mem_w_en_in;
            m.valid = 1'b1;
         end
      end
      q.push_back(m);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_output(mon_e, 1'b0);
         end
      end
   end

   initial begin : stimulus
      rst = 1'b0;
      freeze = 1'b1; flush = 1'b0; hazard = 1'b0;
      pc_in = '0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
      exe_cmd_in = '0; val_rn_in = '0; val_rm_in = '0; imm_in = 0; shift_operand_in = '0;
      signed_imm24_in = '0; dest_in = '0; src1_in = '0; src2_in = '0; sr_in = '0;
      reset_model();
      repeat (2) @(negedge clk);
      check_output(m, 1'b1);
      rst = 1'b1;

      // Directed load
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      pc_in = 32'h10; exe_cmd_in = 4'b0010; shift_operand_in = 12'h1A3; imm_in = 1'b1;
      wb_en_in = 1'b1; val_rn_in = 32'hCAFE_0001; val_rm_in = 32'h0000_0F0F; dest_in = 4'h3;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Freeze with flush asserted and inputs moving
      repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);

      // Flush and hazard together
      randomize_inputs();
      wb_en_in = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);

      // Hazard bubble over a store
      randomize_inputs();
      mem_w_en_in = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 300; i++) begin
         apply_stimulus(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                        1'($urandom_range(0, 4) == 0), 1'b1);
      end

      // Reset in the middle of a frozen cycle, with nonzero state held
      pc_in = 32'hFFFF_FFF0; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1;
      exe_cmd_in = 4'hF; val_rn_in = 32'h1234_5678; val_rm_in = 32'h8765_4321; imm_in = 1;
      shift_operand_in = 12'hFFF; signed_imm24_in = 24'hABCDEF; dest_in = 4'hE;
      src1_in = 4'hD; src2_in = 4'hC; sr_in = 4'hB;
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      reset_model();
      check_output(m, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0), 1'b1);
      end

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
